// File: rtl/c3po_demux_pkg.sv
// Shared types for the c3po packet demultiplexer: input FSM states and FIFO beat layout.
package c3po_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam int BEAT_DATA_W = 256;

  // Beat layout as stored in a port FIFO, most significant field first.
  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [7:0]             vbc;
    logic [BEAT_DATA_W-1:0] data;
  } beat_t;

  localparam int BEAT_HDR_W = $bits(beat_t) - BEAT_DATA_W;

endpackage

// File: rtl/c3po_fifo.sv
// Per-port beat FIFO: power-of-two depth, registered head output, no fall-through.
module c3po_fifo #(
  parameter int WIDTH_P = 266,
  parameter int DEPTH_P = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WIDTH_P-1:0] din,
  input  logic               pop,
  output logic [WIDTH_P-1:0] dout,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH_P);

  logic [WIDTH_P-1:0] mem [DEPTH_P];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [PTR_W:0]     count_reg;
  logic [WIDTH_P-1:0] dout_reg;
  logic               do_push;
  logic               do_pop;

  assign full        = (count_reg == (PTR_W+1)'(DEPTH_P));
  assign empty       = (count_reg == '0);
  assign do_push     = push && !full;
  assign do_pop      = pop && !empty;
  assign rd_ptr_next = do_pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
  assign dout        = dout_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  // Head register reads the next head; a beat written into that slot this cycle bypasses the RAM.
  always_ff @(posedge clk) begin
    if (do_push && (wr_ptr_reg == rd_ptr_next)) dout_reg <= din;
    else                                        dout_reg <= mem[rd_ptr_next];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg <= rd_ptr_next;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/c3po_demux.sv
// Packet demultiplexer: routes packets by id to per-port FIFOs with pkt/byte/drop counters.
// Byte counters are built only when C3PO_DEMUX_BYTE_CNT_EN is defined; otherwise cnt_byte reads 0.
module c3po_demux
  import c3po_demux_pkg::*;
#(
  parameter int PORTS_P    = 4,
  parameter int DATA_W_P   = 256,
  parameter int DEPTH_P    = 8,
  parameter int CNT_SIZE_P = 16,
  parameter int ID_W_P     = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_val,
  input  logic                                 i_sop,
  input  logic                                 i_eop,
  input  logic [ID_W_P-1:0]                    i_id,
  input  logic [7:0]                           i_vbc,
  input  logic [DATA_W_P-1:0]                  i_data,
  output logic                                 i_ready,
  input  logic [PORTS_P-1:0][ID_W_P-1:0]       cfg_port_id,
  input  logic [PORTS_P-1:0]                   cfg_port_enable,
  input  logic [PORTS_P-1:0]                   cnt_clr,
  input  logic [PORTS_P-1:0]                   o_ready,
  output logic [PORTS_P-1:0]                   o_val,
  output logic [PORTS_P-1:0]                   o_sop,
  output logic [PORTS_P-1:0]                   o_eop,
  output logic [PORTS_P-1:0][7:0]              o_vbc,
  output logic [PORTS_P-1:0][DATA_W_P-1:0]     o_data,
  output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]   cnt_pkt,
  output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]   cnt_byte,
  output logic [PORTS_P-1:0][CNT_SIZE_P-1:0]   cnt_drop,
  output logic                                 o_err
);

  localparam int IDX_W  = (PORTS_P > 1) ? $clog2(PORTS_P) : 1;
  localparam int BEAT_W = BEAT_HDR_W + DATA_W_P;

  state_t             state_reg;
  logic [IDX_W-1:0]   tgt_reg;
  logic               err_reg;
  logic               ready_en_reg;

  logic               hit_found;
  logic [IDX_W-1:0]   hit_idx;
  logic               tgt_found;
  logic [IDX_W-1:0]   tgt_idx;
  logic               ready_c;
  logic               xfer;
  logic [PORTS_P-1:0] fifo_full;
  logic [PORTS_P-1:0] fifo_empty;
  logic [PORTS_P-1:0] push_vec;
  logic [PORTS_P-1:0] drop_inc;
  logic [BEAT_W-1:0]  beat_in;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    tgt_found = 1'b0;
    tgt_idx   = '0;
    for (int i = PORTS_P - 1; i >= 0; i--) begin
      if (cfg_port_id[i] == i_id) begin
        hit_found = 1'b1;
        hit_idx   = IDX_W'(i);
        if (cfg_port_enable[i]) begin
          tgt_found = 1'b1;
          tgt_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    ready_c = 1'b1;
    case (state_reg)
      ST_PASS: ready_c = !fifo_full[tgt_reg];
      ST_IDLE: if (i_val && i_sop && tgt_found) ready_c = !fifo_full[tgt_idx];
      default: ready_c = 1'b1;
    endcase
  end

  assign i_ready = ready_en_reg && ready_c;
  assign xfer    = i_val && i_ready;
  assign beat_in = {i_sop, i_eop, i_vbc, i_data};
  assign o_err   = err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tgt_reg      <= '0;
      err_reg      <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      err_reg      <= 1'b0;
      if (xfer) begin
        case (state_reg)
          ST_IDLE: begin
            if (!i_sop) begin
              err_reg <= 1'b1;
            end else if (!i_eop) begin
              state_reg <= tgt_found ? ST_PASS : ST_DROP;
              tgt_reg   <= tgt_idx;
            end
          end
          default: begin
            // A new sop inside a packet aborts the rest of it.
            if (i_sop) begin
              err_reg   <= 1'b1;
              state_reg <= ST_DROP;
            end else if (i_eop) begin
              state_reg <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  generate
    for (genvar gi = 0; gi < PORTS_P; gi++) begin : g_port
      logic [BEAT_W-1:0]     head;
      logic [CNT_SIZE_P-1:0] pkt_reg;
      logic [CNT_SIZE_P-1:0] drop_reg;

      assign push_vec[gi] = xfer &&
        ((state_reg == ST_PASS && !i_sop && tgt_reg == IDX_W'(gi)) ||
         (state_reg == ST_IDLE && i_sop && tgt_found && tgt_idx == IDX_W'(gi)));

      assign drop_inc[gi] = xfer && i_sop &&
        ((state_reg == ST_IDLE && !tgt_found && hit_found && hit_idx == IDX_W'(gi)) ||
         (state_reg == ST_PASS && tgt_reg == IDX_W'(gi)));

      c3po_fifo #(
        .WIDTH_P (BEAT_W),
        .DEPTH_P (DEPTH_P)
      ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push_vec[gi]),
        .din   (beat_in),
        .pop   (o_val[gi] && o_ready[gi]),
        .dout  (head),
        .full  (fifo_full[gi]),
        .empty (fifo_empty[gi])
      );

      assign o_val[gi]  = !fifo_empty[gi];
      assign o_sop[gi]  = o_val[gi] && head[BEAT_W-1];
      assign o_eop[gi]  = o_val[gi] && head[BEAT_W-2];
      assign o_vbc[gi]  = head[DATA_W_P +: 8];
      assign o_data[gi] = head[DATA_W_P-1:0];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pkt_reg  <= '0;
          drop_reg <= '0;
        end else if (cnt_clr[gi]) begin
          pkt_reg  <= '0;
          drop_reg <= '0;
        end else begin
          if (push_vec[gi] && i_eop && pkt_reg != '1) pkt_reg <= pkt_reg + CNT_SIZE_P'(1);
          if (drop_inc[gi] && drop_reg != '1) drop_reg <= drop_reg + CNT_SIZE_P'(1);
        end
      end

      assign cnt_pkt[gi]  = pkt_reg;
      assign cnt_drop[gi] = drop_reg;

`ifdef C3PO_DEMUX_BYTE_CNT_EN
      logic [CNT_SIZE_P-1:0] byte_reg;
      logic [CNT_SIZE_P:0]   byte_sum;

      assign byte_sum = {1'b0, byte_reg} + (CNT_SIZE_P+1)'(i_vbc);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          byte_reg <= '0;
        end else if (cnt_clr[gi]) begin
          byte_reg <= '0;
        end else if (push_vec[gi]) begin
          byte_reg <= byte_sum[CNT_SIZE_P] ? '1 : byte_sum[CNT_SIZE_P-1:0];
        end
      end

      assign cnt_byte[gi] = byte_reg;
`else
      assign cnt_byte[gi] = '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_c3po_demux.sv
// Scoreboard bench for c3po_demux: expected beats queued per port at drive time, popped at output.
module tb_c3po_demux;

  localparam int PORTS = 4;
  localparam int DW    = 32;
  localparam int BW    = 10 + DW;
`ifdef C3PO_DEMUX_BYTE_CNT_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic                        clk;
  logic                        reset;
  logic                        i_val, i_sop, i_eop;
  logic [3:0]                  i_id;
  logic [7:0]                  i_vbc;
  logic [DW-1:0]               i_data;
  logic                        i_ready;
  logic [PORTS-1:0][3:0]       cfg_port_id;
  logic [PORTS-1:0]            cfg_port_enable, cnt_clr, o_ready;
  logic [PORTS-1:0]            o_val, o_sop, o_eop;
  logic [PORTS-1:0][7:0]       o_vbc;
  logic [PORTS-1:0][DW-1:0]    o_data;
  logic [PORTS-1:0][15:0]      cnt_pkt, cnt_byte, cnt_drop;
  logic                        o_err;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  logic [BW-1:0] sb_q [PORTS][$];
  logic [BW-1:0] exp_beat;

  c3po_demux #(
    .PORTS_P(PORTS), .DATA_W_P(DW), .DEPTH_P(8), .CNT_SIZE_P(16), .ID_W_P(4)
  ) dut (
    .clk(clk), .reset(reset),
    .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop), .i_id(i_id), .i_vbc(i_vbc), .i_data(i_data),
    .i_ready(i_ready),
    .cfg_port_id(cfg_port_id), .cfg_port_enable(cfg_port_enable), .cnt_clr(cnt_clr), .o_ready(o_ready),
    .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_vbc(o_vbc), .o_data(o_data),
    .cnt_pkt(cnt_pkt), .cnt_byte(cnt_byte), .cnt_drop(cnt_drop), .o_err(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat was transferred.
  task automatic drive_beat(input logic sop, input logic eop, input logic [3:0] id,
                            input logic [7:0] vbc, input logic [DW-1:0] data,
                            input int exp_port, output int waits);
    i_val = 1'b1; i_sop = sop; i_eop = eop; i_id = id; i_vbc = vbc; i_data = data;
    waits = 0;
    @(negedge clk);
    while (!i_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!i_ready) chk("accept_timeout", i_ready, 1);
    if (exp_port >= 0) sb_q[exp_port].push_back({sop, eop, vbc, data});
    @(posedge clk); #1;
    i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (o_err) err_cnt++;
      for (int p = 0; p < PORTS; p++) begin
        if (o_val[p] && o_ready[p]) begin
          if (sb_q[p].size() == 0) begin
            chk($sformatf("p%0d_unexpected", p), o_val[p], 0);
          end else begin
            exp_beat = sb_q[p].pop_front();
            chk($sformatf("p%0d_beat", p), {o_sop[p], o_eop[p], o_vbc[p], o_data[p]}, exp_beat);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    reset = 1'b1; i_val = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_id = '0; i_vbc = '0; i_data = '0;
    o_ready = '1; cnt_clr = '0;
    cfg_port_id[0] = 4'd3; cfg_port_id[1] = 4'd2; cfg_port_id[2] = 4'd3; cfg_port_id[3] = 4'd9;
    cfg_port_enable = 4'b0111;

    idle(3);
    chk("rst_i_ready", i_ready, 0);
    chk("rst_o_val", o_val, 0);
    chk("rst_o_err", o_err, 0);
    chk("rst_cnt_pkt", cnt_pkt, 0);
    reset = 1'b0;
    idle(1);
    chk("post_rst_i_ready", i_ready, 1);

    // 3-beat packet id 2 to port 1
    drive_beat(1, 0, 2, 32, 32'h1100_0001, 1, w);
    chk("t36_o_val_latency", o_val[1], 1);
    drive_beat(0, 0, 2, 32, 32'h1100_0002, 1, w);
    drive_beat(0, 1, 2, 5,  32'h1100_0003, 1, w);
    idle(4);
    chk("t36_cnt_pkt1", cnt_pkt[1], 1);
    chk("t36_cnt_byte1", cnt_byte[1], BYTE_EN ? 69 : 0);

    // id 3 matches ports 0 and 2; lowest wins
    drive_beat(1, 0, 3, 10, 32'h2200_0001, 0, w);
    drive_beat(0, 1, 3, 4,  32'h2200_0002, 0, w);
    idle(4);
    chk("t37_cnt_pkt0", cnt_pkt[0], 1);
    chk("t37_cnt_pkt2", cnt_pkt[2], 0);

    // backpressure: 10-beat packet into depth-8 FIFO
    o_ready[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_beat(k == 0, 0, 3, 32, 32'h3300_0000 + k, 0, w);
      chk($sformatf("t38_wait%0d", k), w, 0);
    end
    i_val = 1'b1; i_sop = 1'b0; i_eop = 1'b0; i_id = 4'd3; i_vbc = 8'd32; i_data = 32'h3300_0008;
    @(negedge clk);
    chk("t38_stall_i_ready", i_ready, 0);
    chk("t38_stall_o_val", o_val[0], 1);
    @(posedge clk); #1;
    o_ready[0] = 1'b1;
    drive_beat(0, 0, 3, 32, 32'h3300_0008, 0, w);
    drive_beat(0, 1, 3, 32, 32'h3300_0009, 0, w);
    idle(12);
    chk("t38_cnt_pkt0", cnt_pkt[0], 2);

    // disabled matching port 3
    drive_beat(1, 0, 9, 16, 32'h4400_0001, -1, w);
    chk("t39_ready_sop", w, 0);
    drive_beat(0, 1, 9, 16, 32'h4400_0002, -1, w);
    chk("t39_ready_eop", w, 0);
    idle(2);
    chk("t39_cnt_drop3", cnt_drop[3], 1);
    chk("t39_o_val3", o_val[3], 0);

    // unknown id, single-beat packet: counted nowhere
    drive_beat(1, 1, 15, 1, 32'h4500_0001, -1, w);
    idle(1);
    chk("unk_cnt_drop", cnt_drop, {16'd1, 16'd0, 16'd0, 16'd0});

    // sop mid-packet aborts the rest; next packet passes
    drive_beat(1, 0, 2, 8, 32'h5500_0001, 1, w);
    drive_beat(0, 0, 2, 8, 32'h5500_0002, 1, w);
    drive_beat(1, 0, 2, 8, 32'h5500_0003, -1, w);
    chk("t40_err_pulse", o_err, 1);
    drive_beat(0, 0, 2, 8, 32'h5500_0004, -1, w);
    chk("t40_err_low", o_err, 0);
    drive_beat(0, 1, 2, 8, 32'h5500_0005, -1, w);
    drive_beat(1, 0, 2, 8, 32'h5600_0001, 1, w);
    drive_beat(0, 1, 2, 8, 32'h5600_0002, 1, w);
    chk("t40_cnt_drop1", cnt_drop[1], 1);
    // non-sop beat in IDLE
    drive_beat(0, 1, 2, 8, 32'h5700_0001, -1, w);
    chk("idle_nonsop_err", o_err, 1);
    idle(4);
    chk("t40_err_count", err_cnt, 2);
    chk("t40_cnt_pkt1", cnt_pkt[1], 2);

    // counter clear coinciding with eop
    cfg_port_id[2] = 4'd6;
    drive_beat(1, 0, 6, 8, 32'h6600_0001, 2, w);
    chk("t41_byte_before_clr", cnt_byte[2], BYTE_EN ? 8 : 0);
    cnt_clr[2] = 1'b1;
    drive_beat(0, 1, 6, 3, 32'h6600_0002, 2, w);
    cnt_clr[2] = 1'b0;
    chk("t41_clr_cnt_pkt2", cnt_pkt[2], 0);
    chk("t41_clr_cnt_byte2", cnt_byte[2], 0);

    // reset with a partial packet parked in FIFO 0
    o_ready[0] = 1'b0;
    drive_beat(1, 0, 3, 4, 32'h7700_0001, -1, w);
    drive_beat(0, 0, 3, 4, 32'h7700_0002, -1, w);
    chk("t41_parked_o_val0", o_val[0], 1);
    reset = 1'b1;
    idle(2);
    chk("t41_rst_o_val", o_val, 0);
    chk("t41_rst_cnt_pkt", cnt_pkt, 0);
    chk("t41_rst_cnt_drop", cnt_drop, 0);
    chk("t41_rst_i_ready", i_ready, 0);
    reset = 1'b0;
    o_ready = '1;
    idle(1);
    chk("t41_post_rst_i_ready", i_ready, 1);
    idle(5);
    drive_beat(1, 1, 3, 7, 32'h7800_0001, 0, w);
    idle(4);
    chk("t41_after_rst_cnt_pkt0", cnt_pkt[0], 1);

    idle(5);
    for (int p = 0; p < PORTS; p++) chk($sformatf("sb_left_p%0d", p), sb_q[p].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
